// File: rtl/ula_pixel_fetch_pkg.sv
`default_nettype none
// ============================================================================
// ula_pixel_fetch_pkg : FSM encoding, screen geometry and colour helpers
// Revision: 1.0
// ============================================================================
package ula_pixel_fetch_pkg;

  localparam int          SCREEN_ROWS       = 192;
  localparam int          SCREEN_COLS       = 32;
  localparam int          PIX_PER_COL       = 8;
  localparam logic [12:0] ATTR_BASE_DEFAULT = 13'h1800;

  localparam logic [3:0]  LVL_OFF    = 4'h0;
  localparam logic [3:0]  LVL_NORMAL = 4'hC;
  localparam logic [3:0]  LVL_BRIGHT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRE_BMP  = 3'd1,
    ST_PRE_ATTR = 3'd2,
    ST_PRE_LAT  = 3'd3,
    ST_ACTIVE   = 3'd4
  } state_e;

  // Bitmap rows are interleaved in thirds: y[7:6] third, y[2:0] pixel row, y[5:3] char row.
  function automatic logic [12:0] bmp_addr(input logic [7:0] y, input logic [4:0] col);
    return {y[7:6], y[2:0], y[5:3], col};
  endfunction

  function automatic logic [12:0] attr_addr(input logic [12:0] base, input logic [7:0] y,
                                            input logic [4:0] col);
    return base + {3'b000, y[7:3], col};
  endfunction

  // GRB border colour at normal intensity, returned as {r, g, b}.
  function automatic logic [11:0] border_rgb(input logic [2:0] grb);
    return {grb[1] ? LVL_NORMAL : LVL_OFF,
            grb[2] ? LVL_NORMAL : LVL_OFF,
            grb[0] ? LVL_NORMAL : LVL_OFF};
  endfunction

endpackage
`default_nettype wire

// File: rtl/zx_attr_color.sv
`default_nettype none
// ============================================================================
// zx_attr_color : maps (attribute byte, pixel bit, flash phase) to 12-bit RGB
// Revision: 1.0
// ============================================================================
module zx_attr_color
  import ula_pixel_fetch_pkg::*;
(
  input  logic [7:0]  attr_i,
  input  logic        pix_bit_i,
  input  logic        flash_phase_i,
  output logic [11:0] rgb_o
);

  logic       w_swap;
  logic [2:0] w_grb;
  logic [3:0] w_on_lvl;

  // Flashing cells swap ink and paper while the frame counter's top bit is set.
  assign w_swap   = attr_i[7] & flash_phase_i;
  assign w_grb    = (pix_bit_i ^ w_swap) ? attr_i[2:0] : attr_i[5:3];
  assign w_on_lvl = attr_i[6] ? LVL_BRIGHT : LVL_NORMAL;

  assign rgb_o = {w_grb[1] ? w_on_lvl : LVL_OFF,
                  w_grb[2] ? w_on_lvl : LVL_OFF,
                  w_grb[0] ? w_on_lvl : LVL_OFF};

endmodule
`default_nettype wire

// File: rtl/ula_pixel_fetch.sv
`default_nettype none
// ============================================================================
// ula_pixel_fetch : per-line bitmap/attribute fetch and pixel serialiser
// Revision: 1.0
// ============================================================================
module ula_pixel_fetch
  import ula_pixel_fetch_pkg::*;
#(
  parameter int          PIX_DIV   = 2,
  parameter logic [12:0] ATTR_BASE = ATTR_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_num,
  input  logic        frame_start,
  input  logic [2:0]  border_color,
  output logic [12:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic [3:0]  pix_r,
  output logic [3:0]  pix_g,
  output logic [3:0]  pix_b,
  output logic        pixel_valid,
  output logic        busy
);

  localparam int         DIV_SH    = (PIX_DIV == 2) ? 1 : 0;
  localparam logic [9:0] TOTAL_CYC = 10'(SCREEN_COLS * PIX_PER_COL * PIX_DIV);
  localparam logic [9:0] COL_MASK  = 10'(PIX_PER_COL * PIX_DIV - 1);
  localparam logic [9:0] SUB_MASK  = 10'(PIX_DIV - 1);
  localparam logic [4:0] LAST_COL  = 5'(SCREEN_COLS - 1);

  state_e      state_q;
  logic [7:0]  y_q;
  logic [4:0]  flash_q;
  logic [9:0]  cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  attr_q;
  logic [7:0]  hold_bmp_q;
  logic [7:0]  hold_attr_q;
  logic [12:0] vram_addr_q;
  logic [11:0] pix_q;
  logic        valid_q;
  logic        busy_q;

  logic        w_row_ok;
  logic [9:0]  w_n;
  logic [9:0]  w_n_ccl;
  logic [9:0]  w_c_ccl;
  logic [4:0]  w_n_col;
  logic        w_col_edge;
  logic        w_pix_adv;
  logic        w_last;
  logic [7:0]  w_src_attr;
  logic        w_src_bit;
  logic [11:0] w_rgb;
  logic [11:0] w_border;

  // w_n is the active-cycle index that the registered outputs will show next.
  assign w_row_ok   = (line_num < 8'(SCREEN_ROWS));
  assign w_n        = cnt_q + 10'd1;
  assign w_n_ccl    = w_n & COL_MASK;
  assign w_c_ccl    = cnt_q & COL_MASK;
  assign w_n_col    = w_n[DIV_SH+7:DIV_SH+3];
  assign w_col_edge = (w_n_ccl == 10'd0);
  assign w_pix_adv  = ((w_n & SUB_MASK) == 10'd0);
  assign w_last     = (w_n == TOTAL_CYC);
  assign w_border   = border_rgb(border_color);

  always_comb begin
    w_src_attr = attr_q;
    w_src_bit  = shift_q[7];
    if (state_q == ST_PRE_LAT) begin
      w_src_attr = vram_data;
      w_src_bit  = hold_bmp_q[7];
    end else if (w_col_edge) begin
      w_src_attr = hold_attr_q;
      w_src_bit  = hold_bmp_q[7];
    end else if (w_pix_adv) begin
      w_src_bit  = shift_q[6];
    end
  end

  zx_attr_color u_color (
    .attr_i        (w_src_attr),
    .pix_bit_i     (w_src_bit),
    .flash_phase_i (flash_q[4]),
    .rgb_o         (w_rgb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      flash_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      attr_q      <= '0;
      hold_bmp_q  <= '0;
      hold_attr_q <= '0;
      vram_addr_q <= '0;
      pix_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (frame_start) begin
        flash_q <= flash_q + 5'd1;
      end
      if (line_start) begin
        // A new line always discards whatever was in flight.
        pix_q   <= w_border;
        valid_q <= 1'b0;
        cnt_q   <= '0;
        if (w_row_ok) begin
          state_q     <= ST_PRE_BMP;
          busy_q      <= 1'b1;
          y_q         <= line_num;
          vram_addr_q <= bmp_addr(line_num, 5'd0);
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            pix_q <= w_border;
          end
          ST_PRE_BMP: begin
            pix_q       <= w_border;
            vram_addr_q <= attr_addr(ATTR_BASE, y_q, 5'd0);
            state_q     <= ST_PRE_ATTR;
          end
          ST_PRE_ATTR: begin
            pix_q      <= w_border;
            hold_bmp_q <= vram_data;
            state_q    <= ST_PRE_LAT;
          end
          ST_PRE_LAT: begin
            shift_q     <= hold_bmp_q;
            attr_q      <= vram_data;
            pix_q       <= w_rgb;
            valid_q     <= 1'b1;
            cnt_q       <= '0;
            vram_addr_q <= bmp_addr(y_q, 5'd1);
            state_q     <= ST_ACTIVE;
          end
          ST_ACTIVE: begin
            if (w_last) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              pix_q   <= w_border;
            end else begin
              cnt_q <= w_n;
              pix_q <= w_rgb;
              if (w_col_edge) begin
                shift_q <= hold_bmp_q;
                attr_q  <= hold_attr_q;
              end else if (w_pix_adv) begin
                shift_q <= {shift_q[6:0], 1'b0};
              end
              // Prefetch the following column; nothing to fetch past the last one.
              if (w_n_col != LAST_COL) begin
                if (w_n_ccl == 10'd0) begin
                  vram_addr_q <= bmp_addr(y_q, w_n_col + 5'd1);
                end else if (w_n_ccl == 10'd1) begin
                  vram_addr_q <= attr_addr(ATTR_BASE, y_q, w_n_col + 5'd1);
                end
                if (w_c_ccl == 10'd1) begin
                  hold_bmp_q <= vram_data;
                end else if (w_c_ccl == 10'd2) begin
                  hold_attr_q <= vram_data;
                end
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vram_addr   = vram_addr_q;
  assign pix_r       = pix_q[11:8];
  assign pix_g       = pix_q[7:4];
  assign pix_b       = pix_q[3:0];
  assign pixel_valid = valid_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ula_pixel_fetch.sv
`default_nettype none
// ============================================================================
// tb_ula_pixel_fetch : directed vector table plus multi-cycle corner sequences
// Revision: 1.0
// ============================================================================
module tb_ula_pixel_fetch;

  localparam int          PIX_DIV    = 2;
  localparam int          LINE_CYC   = 256 * PIX_DIV;
  localparam logic [11:0] BORDER_RGB = 12'h0CC;  // border 3'b101: G and B set

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [7:0]  line_num;
  logic        frame_start;
  logic [2:0]  border_color;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic [3:0]  pix_r, pix_g, pix_b;
  logic        pixel_valid;
  logic        busy;
  logic [11:0] pix_rgb;

  logic [7:0]  vram [0:8191];
  int          n_checks = 0;
  int          n_fail   = 0;

  typedef struct {
    logic [7:0]  y;
    logic [7:0]  bmp;
    logic [7:0]  attr;
    int          flashes;
    logic [95:0] exp;
  } vec_t;

  vec_t vecs [8];

  ula_pixel_fetch #(.PIX_DIV(PIX_DIV), .ATTR_BASE(13'h1800)) dut (
    .clk          (clk),
    .reset        (reset),
    .line_start   (line_start),
    .line_num     (line_num),
    .frame_start  (frame_start),
    .border_color (border_color),
    .vram_addr    (vram_addr),
    .vram_data    (vram_data),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .pixel_valid  (pixel_valid),
    .busy         (busy)
  );

  assign pix_rgb = {pix_r, pix_g, pix_b};

  always #5 clk = ~clk;

  always @(posedge clk) vram_data <= vram[vram_addr];

  function automatic logic [12:0] bmp_a(input logic [7:0] y);
    return {y[7:6], y[2:0], y[5:3], 5'd0};
  endfunction

  function automatic logic [12:0] attr_a(input logic [7:0] y);
    return 13'h1800 + {3'b000, y[7:3], 5'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Leaves the bench one cycle after the line_start cycle.
  task automatic start_line(input logic [7:0] y);
    line_num   = y;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic drain_line(input string tag, input int already);
    int n     = already;
    int guard = 0;
    while (pixel_valid && guard < 2 * LINE_CYC) begin
      n++;
      guard++;
      tick();
    end
    check({tag, " valid_count"}, n, LINE_CYC);
    check({tag, " busy_fall"}, {31'd0, busy}, 0);
    check({tag, " border_after"}, {20'd0, pix_rgb}, {20'd0, BORDER_RGB});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  initial begin
    int stale;

    vecs[0] = '{y:8'd0,   bmp:8'h80, attr:8'h07, flashes:0,
                exp:{12'hCCC, {7{12'h000}}}};
    vecs[1] = '{y:8'd8,   bmp:8'hFF, attr:8'h42, flashes:0,
                exp:{8{12'hF00}}};
    vecs[2] = '{y:8'd100, bmp:8'hF0, attr:8'hC7, flashes:0,
                exp:{{4{12'hFFF}}, {4{12'h000}}}};
    vecs[3] = '{y:8'd191, bmp:8'h0F, attr:8'h38, flashes:0,
                exp:{{4{12'hCCC}}, {4{12'h000}}}};
    vecs[4] = '{y:8'd50,  bmp:8'hA5, attr:8'h54, flashes:0,
                exp:{12'h0F0, 12'hF00, 12'h0F0, 12'hF00, 12'hF00, 12'h0F0, 12'hF00, 12'h0F0}};
    vecs[5] = '{y:8'd100, bmp:8'hF0, attr:8'hC7, flashes:16,
                exp:{{4{12'h000}}, {4{12'hFFF}}}};
    vecs[6] = '{y:8'd120, bmp:8'h80, attr:8'h47, flashes:0,
                exp:{12'hFFF, {7{12'h000}}}};
    vecs[7] = '{y:8'd100, bmp:8'hF0, attr:8'hC7, flashes:16,
                exp:{{4{12'hFFF}}, {4{12'h000}}}};

    for (int a = 0; a < 8192; a++) vram[a] = 8'h00;

    reset        = 1'b1;
    line_start   = 1'b0;
    line_num     = 8'd0;
    frame_start  = 1'b0;
    border_color = 3'b101;
    repeat (3) tick();
    check("reset valid", {31'd0, pixel_valid}, 0);
    check("reset busy", {31'd0, busy}, 0);
    check("reset pix", {20'd0, pix_rgb}, 0);
    check("reset addr", {19'd0, vram_addr}, 0);
    reset = 1'b0;
    tick();
    check("post_reset border", {20'd0, pix_rgb}, {20'd0, BORDER_RGB});

    for (int v = 0; v < 8; v++) begin
      for (int f = 0; f < vecs[v].flashes; f++) pulse_frame();
      vram[bmp_a(vecs[v].y)]  = vecs[v].bmp;
      vram[attr_a(vecs[v].y)] = vecs[v].attr;
      start_line(vecs[v].y);
      check($sformatf("v%0d busy_on", v), {31'd0, busy}, 1);
      tick();
      tick();
      check($sformatf("v%0d pre_valid", v), {31'd0, pixel_valid}, 0);
      check($sformatf("v%0d pre_border", v), {20'd0, pix_rgb}, {20'd0, BORDER_RGB});
      tick();
      for (int p = 0; p < 8; p++) begin
        for (int d = 0; d < PIX_DIV; d++) begin
          check($sformatf("v%0d px%0d.%0d rgb", v, p, d), {20'd0, pix_rgb},
                {20'd0, vecs[v].exp[95-12*p -: 12]});
          check($sformatf("v%0d px%0d.%0d valid", v, p, d), {31'd0, pixel_valid}, 1);
          tick();
        end
      end
      drain_line($sformatf("v%0d", v), 8 * PIX_DIV);
    end

    // Address sequencing on line 65.
    start_line(8'd65);
    check("addr col0 bmp", {19'd0, vram_addr}, 32'h0900);
    tick();
    check("addr col0 attr", {19'd0, vram_addr}, 32'h1900);
    repeat (34) tick();
    check("addr col3 bmp", {19'd0, vram_addr}, 32'h0903);
    tick();
    check("addr col3 attr", {19'd0, vram_addr}, 32'h1903);
    tick();
    drain_line("line65", 34);
    repeat (3) tick();
    check("addr idle hold", {19'd0, vram_addr}, 32'h191F);

    // Restart mid-line at pixel 100.
    start_line(8'd20);
    repeat (203) tick();
    check("abort mid valid", {31'd0, pixel_valid}, 1);
    start_line(8'd21);
    stale = 0;
    for (int i = 0; i < 3; i++) begin
      if (pixel_valid) stale++;
      tick();
    end
    check("abort no_stale", stale, 0);
    check("abort first_valid", {31'd0, pixel_valid}, 1);
    drain_line("abort", 0);

    // frame_start together with line_start: new flash phase on the new line.
    repeat (15) pulse_frame();
    line_num    = 8'd100;
    line_start  = 1'b1;
    frame_start = 1'b1;
    tick();
    line_start  = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    check("flash_same px0", {20'd0, pix_rgb}, 32'h000);
    repeat (4 * PIX_DIV) tick();
    check("flash_same px4", {20'd0, pix_rgb}, 32'hFFF);
    drain_line("flash_same", 4 * PIX_DIV);

    // Reset mid-line at pixel 50, then a border-only line.
    start_line(8'd30);
    repeat (103) tick();
    check("rst_mid valid_before", {31'd0, pixel_valid}, 1);
    reset = 1'b1;
    tick();
    check("rst_mid valid", {31'd0, pixel_valid}, 0);
    check("rst_mid busy", {31'd0, busy}, 0);
    check("rst_mid pix", {20'd0, pix_rgb}, 0);
    reset = 1'b0;
    tick();
    check("rst_mid border", {20'd0, pix_rgb}, {20'd0, BORDER_RGB});
    start_line(8'd200);
    check("border_line busy", {31'd0, busy}, 0);
    repeat (5) tick();
    check("border_line busy_late", {31'd0, busy}, 0);
    check("border_line valid", {31'd0, pixel_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ula_pixel_fetch.md
ULA_PIXEL_FETCH -- requirements
Module: ula_pixel_fetch

Interface
REQ-001 Parameter PIX_DIV, default 2, clocks per displayed pixel; legal values 1 or 2.
REQ-002 Parameter ATTR_BASE, default 13'h1800, attribute area offset within the 6912-byte screen window.
REQ-003 clk  input  1  video clock; the only clock in the block.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 line_start  input  1  one-cycle pulse at start of a display line; line_num sampled on it.
REQ-006 line_num  input  8  screen row 0..191; any value above 191 means a border-only line.
REQ-007 frame_start  input  1  one-cycle pulse once per frame; advances flash counter.
REQ-008 border_color  input  3  GRB border colour, normal intensity.
REQ-009 vram_addr  output  13  screen RAM read address; data returns on vram_data one clock later.
REQ-010 vram_data  input  8  screen RAM read data.
REQ-011 pix_r, pix_g, pix_b  output  4 each  registered pixel colour.
REQ-012 pixel_valid  output  1  high while one of the 256 active pixels is on pix_*.
REQ-013 busy  output  1  high from line_start acceptance until the last active pixel.

Function
REQ-014 FSM states: IDLE, PRE_BMP, PRE_ATTR, PRE_LAT, ACTIVE.
REQ-015 IDLE -> PRE_BMP on line_start with line_num <= 191; line_start with line_num > 191 keeps IDLE.
REQ-016 PRE_BMP drives column-0 bitmap address; PRE_ATTR drives column-0 attribute address; PRE_LAT captures attribute; column 0 is loaded into the shifter entering ACTIVE.
REQ-017 First pixel_valid cycle is exactly 4 clocks after the line_start cycle.
REQ-018 ACTIVE emits 256 pixels, MSB of bitmap byte first; each pixel is held PIX_DIV clocks; 256*PIX_DIV valid cycles total, contiguous.
REQ-019 During each column, the next column's bitmap address is driven on clock 0 and its attribute address on clock 1 of the column; data is captured one clock later into a holding register and is transferred to the shifter at the column boundary without a gap.
REQ-020 Bitmap address = {y[7:6], y[2:0], y[5:3], col[4:0]}; attribute address = ATTR_BASE + {y[7:3], col[4:0]}; y is the value of line_num latched at line_start.
REQ-021 Attribute decode: bit7 flash, bit6 bright, bits5:3 paper GRB, bits2:0 ink GRB.
REQ-022 Channel level: 4'h0 if off, 4'hC if on and not bright, 4'hF if on and bright.
REQ-023 Flash: 5-bit frame counter increments on frame_start, wraps 31->0; when attribute flash=1 and counter bit4=1, ink and paper are swapped.
REQ-024 When pixel_valid is low, pix_* shows border_color at normal intensity (4'hC per set bit).
REQ-025 After the 256th pixel, FSM returns to IDLE; busy and pixel_valid fall in the same cycle.
REQ-026 line_start while busy aborts the current line and restarts at PRE_BMP with the new line_num; no stale pixels are emitted.
REQ-027 frame_start and line_start in the same cycle: both take effect; the new flash phase applies to the new line.
REQ-028 vram_addr holds its last value in IDLE.

Reset
REQ-029 On reset: FSM IDLE, flash counter 0, shifter and holding registers 0, vram_addr 0, pixel_valid 0, busy 0, pix_* 0.
REQ-030 Reset asserted mid-line takes effect on the next clk edge, discarding the line; first output after release is border.

Structure
REQ-031 Shared package holds FSM state encoding, SCREEN_ROWS=192, SCREEN_COLS=32, ATTR_BASE default and the intensity constants 4'hC/4'hF.
REQ-032 One sub-module, zx_attr_color, combinationally maps (attribute, pixel bit, flash phase) to 12-bit RGB.

Verification
REQ-033 line_num=65, line_start; column 3 -> vram_addr 13'h0903 (bitmap) then 13'h1903 (attribute).
REQ-034 line 0, col0 bitmap 0x80 attr 0x07 -> cycle 4 pix=C,C,C for PIX_DIV=2 clocks, next 7 pixels 0,0,0; then border.
REQ-035 attr 0x42, bitmap 0xFF -> all 8 pixels pix_r=F, pix_g=0, pix_b=0.
REQ-036 attr 0xC7, bitmap 0xF0; after 16 frame_start pulses first 4 pixels 0,0,0 and last 4 F,F,F; after 32 pulses original pattern.
REQ-037 line_start at pixel 100, then line_start again -> exactly 256*PIX_DIV valid cycles follow, starting 4 clocks after the second pulse.
REQ-038 reset at pixel 50 -> next cycle pixel_valid=0, busy=0, pix_*=0; line_num=200 line_start -> busy stays 0.
